// File: rtl/stage_mem_lsu_if.sv
// rtl/stage_mem_lsu_if.sv - data-memory bus between the MEM-stage LSU and the memory port
interface stage_mem_lsu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) ();
  localparam int NB = DATA_W / 8;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] dmem_address;
  logic [DATA_W-1:0] dmem_wdata;
  logic [NB-1:0]     mem_byte_enable;
  logic [DATA_W-1:0] d_rdata;
  logic              d_resp;

  modport master (
    output d_read,
    output d_write,
    output dmem_address,
    output dmem_wdata,
    output mem_byte_enable,
    input  d_rdata,
    input  d_resp
  );

  modport slave (
    input  d_read,
    input  d_write,
    input  dmem_address,
    input  dmem_wdata,
    input  mem_byte_enable,
    output d_rdata,
    output d_resp
  );
endinterface

// File: rtl/stage_mem_lsu.sv
// rtl/stage_mem_lsu.sv - MEM-stage load/store unit: lane steering, load extension, bus handshake
module stage_mem_lsu #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] store_data,
  stage_mem_lsu_if.master   dbus,
  output logic              stall,
  output logic [DATA_W-1:0] data_to_wb,
  output logic              wb_valid,
  output logic              misaligned,
  output logic              bus_err
);
  localparam int NB   = DATA_W / 8;
  localparam int OB   = $clog2(NB);
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state_q, state_d;
  logic              req;
  logic              unaligned;
  logic              bad_code;
  logic              mis_in;
  logic [OB-1:0]     off_in;
  logic [NB-1:0]     size_mask;
  logic [NB-1:0]     be_in;
  logic [DATA_W-1:0] wdata_in;
  logic [ADDR_W-1:0] addr_aligned;

  logic              stall_c;
  logic              accept;
  logic              finish_ok;
  logic              finish_to;
  logic              finish_mis;

  logic [OB-1:0]     off_q;
  logic [2:0]        f3_q;
  logic              ld_q;
  logic              mis_q;
  logic              berr_q;
  logic [TO_W-1:0]   to_cnt;

  logic [DATA_W-1:0] ld_shift;
  logic [DATA_W-1:0] lo_mask;
  logic              sign_bit;
  logic [DATA_W-1:0] ld_ext;

  assign req          = valid_in & (is_load | is_store);
  assign off_in       = addr_in[OB-1:0];
  assign addr_aligned = {addr_in[ADDR_W-1:OB], OB'(0)};
  assign wdata_in     = store_data << {off_in, 3'b000};
  assign bad_code     = (DATA_W == 32) &&
                        (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111);
  assign mis_in       = unaligned | bad_code;

  // Access size comes from funct3[1:0]; the sign/unsigned bit only matters on loads.
  always_comb begin
    unaligned = 1'b0;
    size_mask = '1;
    case (funct3[1:0])
      2'b00: begin unaligned = 1'b0;          size_mask = NB'(4'h1); end
      2'b01: begin unaligned = addr_in[0];    size_mask = NB'(4'h3); end
      2'b10: begin unaligned = |addr_in[1:0]; size_mask = NB'(4'hF); end
      default: begin unaligned = |addr_in[2:0]; size_mask = '1; end
    endcase
    be_in = is_load ? '1 : (size_mask << off_in);
  end

  always_comb begin
    state_d    = state_q;
    stall_c    = 1'b0;
    accept     = 1'b0;
    finish_ok  = 1'b0;
    finish_to  = 1'b0;
    finish_mis = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          stall_c = 1'b1;
          if (mis_in) begin
            state_d    = DONE;
            finish_mis = 1'b1;
          end else begin
            state_d = BUSY;
            accept  = 1'b1;
          end
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        // A response in the timeout cycle still counts as a normal completion.
        if (dbus.d_resp) begin
          state_d   = DONE;
          finish_ok = 1'b1;
        end else if (TIMEOUT > 0 && to_cnt == TO_LAST) begin
          state_d   = DONE;
          finish_to = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign ld_shift = dbus.d_rdata >> {off_q, 3'b000};

  always_comb begin
    lo_mask  = '1;
    sign_bit = 1'b0;
    case (f3_q[1:0])
      2'b00: begin lo_mask = DATA_W'(8'hFF);         sign_bit = ld_shift[7];  end
      2'b01: begin lo_mask = DATA_W'(16'hFFFF);      sign_bit = ld_shift[15]; end
      2'b10: begin lo_mask = DATA_W'(32'hFFFF_FFFF); sign_bit = ld_shift[31]; end
      default: begin lo_mask = '1; sign_bit = 1'b0; end
    endcase
    ld_ext = (ld_shift & lo_mask) | ({DATA_W{sign_bit & ~f3_q[2]}} & ~lo_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q              <= IDLE;
      dbus.d_read          <= 1'b0;
      dbus.d_write         <= 1'b0;
      dbus.dmem_address    <= '0;
      dbus.dmem_wdata      <= '0;
      dbus.mem_byte_enable <= '0;
      data_to_wb           <= '0;
      off_q                <= '0;
      f3_q                 <= '0;
      ld_q                 <= 1'b0;
      mis_q                <= 1'b0;
      berr_q               <= 1'b0;
      to_cnt               <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        dbus.d_read          <= is_load;
        dbus.d_write         <= ~is_load;
        dbus.dmem_address    <= addr_aligned;
        dbus.dmem_wdata      <= wdata_in;
        dbus.mem_byte_enable <= be_in;
        off_q                <= off_in;
        f3_q                 <= funct3;
        ld_q                 <= is_load;
        to_cnt               <= '0;
      end else if (state_q == BUSY && state_d == BUSY) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      if (finish_ok || finish_to || finish_mis) begin
        dbus.d_read  <= 1'b0;
        dbus.d_write <= 1'b0;
        mis_q        <= finish_mis;
        berr_q       <= finish_to;
        data_to_wb   <= (finish_ok && ld_q) ? ld_ext : '0;
      end
    end
  end

  assign stall      = stall_c & rst_n;
  assign wb_valid   = (state_q == DONE);
  assign misaligned = (state_q == DONE) & mis_q;
  assign bus_err    = (state_q == DONE) & berr_q;
endmodule

// File: tb/tb_stage_mem_lsu.sv
// tb/tb_stage_mem_lsu.sv - bench for stage_mem_lsu: 32-bit (TIMEOUT=4) and 64-bit (no timeout) instances
module tb_stage_mem_lsu;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in, is_load, is_store, d_resp;
  logic [2:0]  funct3;
  logic [31:0] addr_in;
  logic [63:0] store_data, d_rdata;
  bit          cmp_en = 0;

  always #5 clk = ~clk;

  stage_mem_lsu_if #(.DATA_W(32), .ADDR_W(32)) bus32 ();
  stage_mem_lsu_if #(.DATA_W(64), .ADDR_W(32)) bus64 ();
  assign bus32.d_rdata = d_rdata[31:0];
  assign bus32.d_resp  = d_resp;
  assign bus64.d_rdata = d_rdata;
  assign bus64.d_resp  = d_resp;

  logic        stall32, wb32, mis32, berr32, stall64, wb64, mis64, berr64;
  logic [31:0] dwb32;
  logic [63:0] dwb64;

  stage_mem_lsu #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u32 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr_in(addr_in), .store_data(store_data[31:0]), .dbus(bus32.master),
    .stall(stall32), .data_to_wb(dwb32), .wb_valid(wb32), .misaligned(mis32), .bus_err(berr32));

  stage_mem_lsu #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(0)) u64 (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr_in(addr_in), .store_data(store_data), .dbus(bus64.master),
    .stall(stall64), .data_to_wb(dwb64), .wb_valid(wb64), .misaligned(mis64), .bus_err(berr64));

  logic [1:0]        o_rd, o_wr, o_stall, o_wb, o_mis, o_berr;
  logic [1:0][63:0]  o_wdata, o_dwb;
  logic [1:0][31:0]  o_addr;
  logic [1:0][7:0]   o_be;
  assign o_rd     = {bus64.d_read, bus32.d_read};
  assign o_wr     = {bus64.d_write, bus32.d_write};
  assign o_stall  = {stall64, stall32};
  assign o_wb     = {wb64, wb32};
  assign o_mis    = {mis64, mis32};
  assign o_berr   = {berr64, berr32};
  assign o_wdata[0] = {32'h0, bus32.dmem_wdata};
  assign o_wdata[1] = bus64.dmem_wdata;
  assign o_dwb[0]   = {32'h0, dwb32};
  assign o_dwb[1]   = dwb64;
  assign o_addr[0]  = bus32.dmem_address;
  assign o_addr[1]  = bus64.dmem_address;
  assign o_be[0]    = {4'h0, bus32.mem_byte_enable};
  assign o_be[1]    = bus64.mem_byte_enable;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit misal(int nb, logic [2:0] f3, logic [31:0] a);
    int sz;
    sz = 1 << f3[1:0];
    if (nb == 4 && (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)) return 1'b1;
    return (a % sz) != 0;
  endfunction

  function automatic logic [63:0] ld_extract(int nb, logic [2:0] f3, int off, logic [63:0] rd);
    int sz;
    logic [63:0] v, m;
    sz = 1 << f3[1:0];
    v  = (nb == 4) ? {32'h0, rd[31:0]} : rd;
    v  = v >> (8 * off);
    m  = (sz == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * sz)) - 64'd1);
    v  = v & m;
    if (!f3[2] && v[8*sz-1]) v = v | ~m;
    if (nb == 4) v = v & 64'hFFFF_FFFF;
    return v;
  endfunction

  // Transaction-level reference: one outstanding access per instance, scheduled by cycle number.
  int          to_lim[2] = '{4, 0};
  int          nbv[2]    = '{4, 8};
  bit          act[2];
  longint      acc[2], done_at[2];
  bit          m_ld[2], m_mis[2], m_berr[2];
  logic [2:0]  m_f3[2];
  int          m_off[2];
  logic [63:0] m_data[2], m_wdata[2];
  logic [31:0] m_addr[2];
  logic [7:0]  m_be[2];
  longint      cyc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act[0] = 0;
      act[1] = 0;
      cyc    = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (act[k]) begin
          if (cyc == done_at[k]) act[k] = 0;
          else if (done_at[k] < 0) begin
            if (d_resp) begin
              done_at[k] = cyc + 1;
              m_data[k]  = m_ld[k] ? ld_extract(nbv[k], m_f3[k], m_off[k], d_rdata) : 64'h0;
            end else if (to_lim[k] > 0 && (cyc - acc[k]) == to_lim[k]) begin
              done_at[k] = cyc + 1;
              m_berr[k]  = 1;
              m_data[k]  = 64'h0;
            end
          end
        end else if (valid_in && (is_load || is_store)) begin
          logic [63:0] sd;
          int          bem;
          act[k]    = 1;
          acc[k]    = cyc;
          m_ld[k]   = is_load;
          m_f3[k]   = funct3;
          m_off[k]  = int'(addr_in[2:0]) % nbv[k];
          m_mis[k]  = misal(nbv[k], funct3, addr_in);
          m_berr[k] = 0;
          m_data[k] = 64'h0;
          m_addr[k] = addr_in & ~(32'(nbv[k] - 1));
          bem       = is_load ? ((1 << nbv[k]) - 1)
                              : ((((1 << (1 << funct3[1:0])) - 1) << m_off[k]) & ((1 << nbv[k]) - 1));
          m_be[k]   = 8'(bem);
          sd        = (nbv[k] == 4) ? {32'h0, store_data[31:0]} : store_data;
          m_wdata[k] = sd << (8 * m_off[k]);
          if (nbv[k] == 4) m_wdata[k] = m_wdata[k] & 64'hFFFF_FFFF;
          done_at[k] = m_mis[k] ? cyc + 1 : -1;
        end
      end
      cyc++;
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        bit e_rd, e_wr, e_st, e_wb, e_mis, e_berr;
        e_rd = 0; e_wr = 0; e_st = 0; e_wb = 0; e_mis = 0; e_berr = 0;
        if (act[k] && cyc == done_at[k]) begin
          e_wb   = 1;
          e_mis  = m_mis[k];
          e_berr = m_berr[k];
          if (m_ld[k] || m_mis[k] || m_berr[k])
            chk($sformatf("data_to_wb[%0d]", k), o_dwb[k], m_data[k]);
        end else if (act[k]) begin
          e_rd = m_ld[k];
          e_wr = !m_ld[k];
          e_st = 1;
          chk($sformatf("dmem_address[%0d]", k), 64'(o_addr[k]), 64'(m_addr[k]));
          chk($sformatf("byte_enable[%0d]", k), 64'(o_be[k]), 64'(m_be[k]));
          if (!m_ld[k]) chk($sformatf("dmem_wdata[%0d]", k), o_wdata[k], m_wdata[k]);
        end else begin
          e_st = valid_in && (is_load || is_store);
        end
        chk($sformatf("d_read[%0d]", k), 64'(o_rd[k]), 64'(e_rd));
        chk($sformatf("d_write[%0d]", k), 64'(o_wr[k]), 64'(e_wr));
        chk($sformatf("stall[%0d]", k), 64'(o_stall[k]), 64'(e_st));
        chk($sformatf("wb_valid[%0d]", k), 64'(o_wb[k]), 64'(e_wb));
        chk($sformatf("misaligned[%0d]", k), 64'(o_mis[k]), 64'(e_mis));
        chk($sformatf("bus_err[%0d]", k), 64'(o_berr[k]), 64'(e_berr));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    valid_in = 0;
    is_load  = 0;
    is_store = 0;
  endtask

  task automatic drain();
    idle_in();
    d_resp = 1;
    repeat (3) tick();
    d_resp = 0;
  endtask

  task automatic req(input bit ld, input logic [2:0] f3, input logic [31:0] a);
    valid_in = 1;
    is_load  = ld;
    is_store = !ld;
    funct3   = f3;
    addr_in  = a;
  endtask

  initial begin
    int n_st, n_wr;
    valid_in = 1; is_load = 1; is_store = 0; funct3 = 3'b010; addr_in = 32'h0;
    store_data = 64'h0; d_rdata = 64'h0; d_resp = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall32", stall32, 0);
    chk("rst_stall64", stall64, 0);
    chk("rst_dread32", bus32.d_read, 0);
    chk("rst_dwrite64", bus64.d_write, 0);
    chk("rst_addr32", bus32.dmem_address, 0);
    chk("rst_be64", bus64.mem_byte_enable, 0);
    chk("rst_wdata64", bus64.dmem_wdata, 0);
    chk("rst_dwb32", dwb32, 0);
    chk("rst_wb32", wb32, 0);
    idle_in();
    rst_n  = 1;
    cmp_en = 1;
    tick();

    // lb at 0x1003
    drain();
    req(1, 3'b000, 32'h1003); d_rdata = 64'h0000_0000_80FF_FF00;
    @(negedge clk); chk("lb_stall_c1", stall32, 1);
    tick(); idle_in(); d_resp = 1;
    @(negedge clk); chk("lb_dread_c2", bus32.d_read, 1); chk("lb_addr", bus32.dmem_address, 32'h1000);
    tick(); d_resp = 0;
    @(negedge clk);
    chk("lb_wb_c3", wb32, 1);
    chk("lb_data32", dwb32, 32'hFFFF_FF80);
    chk("lb_data64", dwb64, 64'hFFFF_FFFF_FFFF_FF80);
    chk("lb_dread_c3", bus32.d_read, 0);
    tick();
    @(negedge clk); chk("lb_wb_c4", wb32, 0);

    // sh at 0x2006, response on the fourth BUSY cycle
    drain();
    n_st = 0; n_wr = 0;
    for (int i = 1; i <= 7; i++) begin
      if (i == 1) begin
        req(0, 3'b001, 32'h2006); store_data = 64'h0000_0000_0000_ABCD; d_resp = 0;
      end else begin
        tick(); idle_in(); d_resp = (i == 5);
      end
      @(negedge clk);
      n_st += int'(stall64);
      n_wr += int'(bus64.d_write);
      if (i == 3) begin
        chk("sh_be64", bus64.mem_byte_enable, 8'hC0);
        chk("sh_wdata64_hi", bus64.dmem_wdata[63:48], 16'hABCD);
        chk("sh_be32", bus32.mem_byte_enable, 4'hC);
      end
      if (i == 6) begin
        chk("sh_wb64", wb64, 1);
        chk("sh_wb32", wb32, 1);
        chk("resp_beats_timeout", berr32, 0);
      end
    end
    chk("sh_stall_cycles", n_st, 5);
    chk("sh_dwrite_cycles", n_wr, 4);

    // lw at 0x1002 is misaligned
    drain();
    req(1, 3'b010, 32'h1002); d_rdata = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk); chk("lw_mis_stall", stall32, 1); chk("lw_mis_noread_c1", bus32.d_read, 0);
    tick(); idle_in();
    @(negedge clk);
    chk("lw_mis_wb", wb32, 1); chk("lw_mis_flag", mis32, 1);
    chk("lw_mis_data", dwb32, 0); chk("lw_mis_noread_c2", bus32.d_read, 0);
    chk("lw_mis_flag64", mis64, 1);
    tick();
    @(negedge clk); chk("lw_mis_clear", mis32, 0);

    // load with no response: 32-bit instance times out after 4 BUSY cycles
    drain();
    req(1, 3'b010, 32'h1000); d_rdata = 64'hDEAD_BEEF_CAFE_F00D; d_resp = 0;
    for (int i = 2; i <= 6; i++) begin
      tick(); idle_in();
      @(negedge clk);
      if (i == 5) chk("to_still_busy", wb32, 0);
      if (i == 6) begin
        chk("to_wb", wb32, 1); chk("to_berr", berr32, 1); chk("to_data", dwb32, 0);
        chk("no_to_64", stall64, 1);
      end
    end
    drain();

    // lhu at 0x1002
    req(1, 3'b101, 32'h1002); d_rdata = 64'h0000_0000_8001_0000; d_resp = 0;
    tick(); idle_in(); d_resp = 1;
    tick(); d_resp = 0;
    @(negedge clk); chk("lhu_data32", dwb32, 32'h0000_8001); chk("lhu_data64", dwb64, 64'h8001);

    // reset in the middle of BUSY abandons the access
    drain();
    req(1, 3'b010, 32'h1000);
    tick(); idle_in();
    @(negedge clk); chk("rstb_dread_before", bus32.d_read, 1);
    #1 rst_n = 0;
    #1;
    chk("rstb_dread32", bus32.d_read, 0); chk("rstb_stall32", stall32, 0);
    chk("rstb_dread64", bus64.d_read, 0); chk("rstb_stall64", stall64, 0);
    @(posedge clk); #1 rst_n = 1; d_resp = 1;
    @(negedge clk); chk("rstb_no_wb1", wb32, 0);
    tick(); d_resp = 0;
    @(negedge clk); chk("rstb_no_wb2", wb32, 0); chk("rstb_no_wb64", wb64, 0);

    // random traffic
    for (int n = 0; n < 4000; n++) begin
      tick();
      valid_in   = ($urandom_range(0, 1) == 1);
      is_load    = ($urandom_range(0, 1) == 1);
      is_store   = ($urandom_range(0, 1) == 1);
      funct3     = 3'($urandom_range(0, 7));
      addr_in    = $urandom & (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFF8 : 32'hFFFF_FFFF);
      store_data = {$urandom, $urandom};
      d_rdata    = {$urandom, $urandom};
      d_resp     = ($urandom_range(0, 3) == 0);
    end
    drain();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stage_mem_lsu.md
STAGE_MEM_LSU -- requirements
Module: stage_mem_lsu

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving data bus width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter ADDR_W, default 32, giving the byte-address width.
REQ-003 The block SHALL have parameter TIMEOUT, default 0, giving the maximum BUSY cycles before a bus error; 0 disables the timeout.
REQ-004 Let NB = DATA_W/8 and OB = log2(NB).
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-006 Port clk: input, 1 bit, rising-edge clock.
REQ-007 Port rst_n: input, 1 bit, async active-low reset.
REQ-008 Port valid_in: input, 1 bit, the MEM-stage instruction is valid.
REQ-009 Port is_load, is_store: inputs, 1 bit each, decoded operation.
REQ-010 Port funct3: input, 3 bits, RV size/sign code (000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu).
REQ-011 Port addr_in: input, ADDR_W bits, effective byte address.
REQ-012 Port store_data: input, DATA_W bits, rs2 value (forwarding already resolved).
REQ-013 Port d_rdata: input, DATA_W bits, memory read data.
REQ-014 Port d_resp: input, 1 bit, memory completion strobe.
REQ-015 Port d_read, d_write: outputs, 1 bit each, registered memory request.
REQ-016 Port dmem_address: output, ADDR_W bits, addr_in with bits [OB-1:0] zeroed.
REQ-017 Port dmem_wdata: output, DATA_W bits, lane-shifted store data.
REQ-018 Port mem_byte_enable: output, NB bits, write lane mask.
REQ-019 Port stall: output, 1 bit, holds the pipeline.
REQ-020 Port data_to_wb: output, DATA_W bits, registered load result.
REQ-021 Port wb_valid: output, 1 bit, one-cycle completion pulse.
REQ-022 Port misaligned, bus_err: outputs, 1 bit each, fault flags, valid with wb_valid.

Function
REQ-023 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-024 In IDLE, an access is a request when valid_in=1 and (is_load or is_store); if both are high the access SHALL be treated as a load.
REQ-025 Access size SHALL be 1, 2, 4 or 8 bytes per funct3; alignment is required when addr_in mod size = 0.
REQ-026 For DATA_W=32, funct3 011/110/111 SHALL be flagged as misaligned.
REQ-027 On an aligned request in IDLE, the block SHALL register the address, lanes, wdata, funct3 and op, drive stall=1 combinationally, and go to BUSY.
REQ-028 On a misaligned request in IDLE, the block SHALL drive stall=1, issue no memory request, and go to DONE with misaligned=1 and data_to_wb=0.
REQ-029 In BUSY, the block SHALL hold d_read (load) or d_write (store) at 1, keep stall=1, and hold address, wdata and enables stable.
REQ-030 When d_resp=1 in BUSY, the block SHALL go to DONE; for a load, data_to_wb SHALL capture the lane-extracted, sign- or zero-extended d_rdata.
REQ-031 If TIMEOUT>0 and BUSY lasts TIMEOUT cycles without d_resp, the block SHALL go to DONE with bus_err=1 and data_to_wb=0.
REQ-032 A d_resp arriving in the same cycle as the timeout SHALL win.
REQ-033 In DONE, the block SHALL drive wb_valid=1, stall=0 and d_read=d_write=0, then go unconditionally to IDLE; valid_in SHALL be ignored in DONE.
REQ-034 Store lanes: mem_byte_enable SHALL be the size mask (1, 3, 0xF or 0xFF) shifted left by addr[OB-1:0]; dmem_wdata SHALL be store_data shifted left by 8*addr[OB-1:0].
REQ-035 For a load, mem_byte_enable SHALL be all ones.
REQ-036 Load extraction: the selected bytes from d_rdata SHALL start at offset addr[OB-1:0]; b/h/w SHALL sign-extend; bu/hu/wu SHALL zero-extend to DATA_W.
REQ-037 Minimum load/store latency SHALL be 3 cycles (accept, BUSY with d_resp, DONE); each extra wait cycle SHALL add 1.
REQ-038 When the request is not valid in IDLE, stall SHALL be 0 and wb_valid SHALL be 0.
REQ-039 misaligned and bus_err SHALL be 0 outside DONE.

Reset
REQ-040 While rst_n=0, the block SHALL immediately force: state IDLE, d_read=0, d_write=0, dmem_address=0, dmem_wdata=0, mem_byte_enable=0, data_to_wb=0, wb_valid=0, misaligned=0, bus_err=0, stall=0, and timeout counter=0.
REQ-041 Reset asserted in BUSY SHALL abandon the access; a d_resp arriving after reset releases SHALL be ignored in IDLE.

Verification
REQ-042 DATA_W=32, lb at 0x1003, d_rdata=0x80FF_FF00 -> dmem_address=0x1000; d_read=1 for 1 cycle; data_to_wb=0xFFFF_FF80; wb_valid on cycle 3.
REQ-043 DATA_W=64, sh at 0x2006 with store_data=0xABCD -> mem_byte_enable=0xC0; dmem_wdata[63:48]=0xABCD; d_write held through 4 wait cycles; stall=1 for 5 cycles.
REQ-044 lw at 0x1002 -> no d_read; misaligned=1 and wb_valid=1 on cycle 2; data_to_wb=0.
REQ-045 TIMEOUT=4, load with no d_resp -> bus_err=1 after 4 BUSY cycles; d_resp arriving on cycle 4 instead -> normal completion with bus_err=0.
REQ-046 rst_n low in mid-BUSY -> d_read=0 and stall=0 asynchronously; a later d_resp produces no wb_valid.
REQ-047 lhu at 0x1002, d_rdata=0x8001_0000 -> data_to_wb=0x0000_8001.
